// File: rtl/twos_comp_bcd.sv
// Signed/unsigned word to packed BCD converter using a multi-cycle double-dabble engine.
// Optional leading-zero blanking is enabled by defining TWOS_COMP_BCD_LZB_EN.
module twos_comp_bcd #(
  parameter  int DATA_W = 16,
  parameter  int DIGITS = 5,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_signed,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_neg,
  output logic                  o_ovf
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mag_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] bcd_disp;
  logic                neg_q;
  logic                ovf_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                is_neg;

  assign o_ready = (state_q == IDLE);
  assign o_valid = (state_q == DONE);
  assign is_neg  = i_signed & i_data[DATA_W-1];

  // Add-3 correction per digit; digits never carry into each other.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

`ifdef TWOS_COMP_BCD_LZB_EN
  logic seen_nz;

  // Digit 0 is never blanked so a zero result still shows "0".
  always_comb begin
    bcd_disp = bcd_q;
    seen_nz  = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      if (!seen_nz) bcd_disp[4*i +: 4] = 4'hF;
    end
  end
`else
  assign bcd_disp = bcd_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid)         state_d = CONV;
      CONV:    if (cnt_q == '0)     state_d = DONE;
      DONE:    if (i_ready)         state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mag_q <= '0;
      bcd_q <= '0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      o_bcd <= '0;
      o_neg <= 1'b0;
      o_ovf <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid) begin
            neg_q <= is_neg;
            mag_q <= is_neg ? (~i_data + DATA_W'(1)) : i_data;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= CNT_W'(DATA_W);
          end
        end
        CONV: begin
          if (cnt_q != '0) begin
            {bcd_q, mag_q} <= {bcd_adj[4*DIGITS-2:0], mag_q, 1'b0};
            ovf_q          <= ovf_q | bcd_adj[4*DIGITS-1];
            cnt_q          <= cnt_q - CNT_W'(1);
          end else begin
            // Result registers only update here, so they hold through IDLE/CONV.
            o_bcd <= bcd_disp;
            o_neg <= neg_q;
            o_ovf <= ovf_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/twos_comp_bcd.md
Name: twos_comp_bcd

Overview:
- Parametrised successor to the combinational two's-complement output stage.
- Takes a DATA_W-bit word, interpreted as signed or unsigned per transaction, and produces a sign flag plus DIGITS packed BCD digits for the 7-segment display path.
- Uses a multi-cycle double-dabble engine behind valid/ready handshakes on both sides.
- Sits between the arithmetic datapath and the segment decoders.

Parameters:
- DATA_W, 16, input word width; must be >= 2.
- DIGITS, 5, number of BCD output digits; must be >= 1.
- CNT_W, $clog2(DATA_W+1), iteration counter width; derived, not overridden.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input word present.
- o_ready  output  1  block can accept a word.
- i_data  input  DATA_W  word to convert.
- i_signed  input  1  1 = two's complement, 0 = unsigned; sampled with i_data.
- o_valid  output  1  result present.
- i_ready  input  1  consumer accepts result.
- o_bcd  output  4*DIGITS  packed BCD; digit 0 (units) in bits [3:0].
- o_neg  output  1  result is negative.
- o_ovf  output  1  magnitude >= 10^DIGITS; o_bcd holds the truncated low-order digits.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: state IDLE, o_valid=0, o_bcd=0, o_neg=0, o_ovf=0, counter=0. o_ready=1 once reset deasserts.
- FSM states: IDLE, CONV, DONE.
- o_ready = (state==IDLE); it is purely a decode of state.
- IDLE:
  - On i_valid & o_ready, latch the magnitude register and the sign, clear the BCD shift register and ovf, load counter=DATA_W, and go to CONV.
  - Signed mode with i_data[DATA_W-1]=1: neg=1, magnitude = ~i_data + 1, held as an unsigned DATA_W-bit value. The most-negative input (e.g. 16'h8000) gives magnitude 32768 with no loss.
  - Otherwise: neg=0, magnitude = i_data.
- CONV, one iteration per cycle:
  - Every digit >= 5 has 3 added to it.
  - Then {bcd, mag} is shifted left by 1.
  - A 1 shifted out of the top digit sets ovf, which is sticky.
  - Counter decrements; when it reaches 0, go to DONE.
- DONE:
  - o_valid=1; o_bcd, o_neg and o_ovf are registered and stable.
  - On i_ready, go to IDLE next cycle with o_valid=0. Outputs keep their last values until the next DONE.
  - While i_ready=0, hold all outputs and stay in DONE.
- Negative zero cannot occur: a magnitude of 0 always gives neg=0.
- Latency: o_valid rises DATA_W+1 cycles after the accept edge. Minimum issue interval is DATA_W+2 cycles. There is no back-to-back accept, because o_ready=0 outside IDLE.
- Inputs are ignored outside IDLE; i_data is never re-sampled mid-conversion.
- Reset mid-operation: asynchronously abandons the conversion and returns to the reset values. A partial result is never presented.
- Widths: the magnitude path is exactly DATA_W bits; all BCD adds are 4-bit, with no carry between digits other than via the shift.

Optional Feature:
- Macro: TWOS_COMP_BCD_LZB_EN (leading-zero blanking).
- Defined: in DONE, every digit above the most significant non-zero digit is replaced by 4'hF, the segment-decoder blank code. Digit 0 is never blanked, so value 0 shows "0". o_neg is unaffected.
- Undefined: leading digits are output as 4'h0.
- Either way, blanking does not alter o_ovf or latency.

Test Plan:
- Signed mode, i_data=16'hFFFF -> after 17 cycles: o_neg=1, o_bcd=20'h00001, o_ovf=0.
- Signed mode, i_data=16'h8000 -> o_neg=1, o_bcd=20'h32768. Same data in unsigned mode -> o_neg=0, o_bcd=20'h32768.
- Unsigned mode, i_data=16'hFFFF -> o_neg=0, o_bcd=20'h65535. Signed mode, i_data=16'h0000 -> o_neg=0, o_bcd=0.
- Overflow, DIGITS=3, unsigned, i_data=1234 -> o_ovf=1, o_bcd=12'h234.
- Backpressure: hold i_ready=0 for 10 cycles in DONE with input 16'hFFD6 (signed) -> o_valid and o_neg=1 / o_bcd=20'h00042 stay stable, o_ready=0. Then i_ready=1 -> IDLE and o_ready=1 the next cycle.
- Reset mid-operation: pulse i_rst_n low 5 cycles after accept -> o_valid=0, o_ready=1 after release, outputs cleared, no stale o_valid. With TWOS_COMP_BCD_LZB_EN defined, 42 -> o_bcd=20'hFFF42 and 0 -> 20'hFFFF0.
